// File: rtl/lsm_pkg.sv
// Shared definitions for the LDM/STM register-list sequencer: microcode
// command codes, sequencer states and the P/U addressing-mode encodings.
package lsm_pkg;

    localparam int NREG       = 16;
    localparam int WORD_BYTES = 4;

    localparam logic [2:0] LSM_NOP   = 3'b000;
    localparam logic [2:0] LSM_LOAD  = 3'b001;
    localparam logic [2:0] LSM_NEXT  = 3'b010;
    localparam logic [2:0] LSM_ABORT = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } lsm_state_t;

    // Modes are indexed by {P, U} = IR[24:23]
    localparam logic [1:0] MODE_DA = 2'b00;
    localparam logic [1:0] MODE_IA = 2'b01;
    localparam logic [1:0] MODE_DB = 2'b10;
    localparam logic [1:0] MODE_IB = 2'b11;

endpackage

// File: rtl/lsm_sequencer_if.sv
// Control-unit <-> sequencer connection: microword command in, condition
// flags and datapath transfer information out.
interface lsm_sequencer_if;

    logic [31:0] ir;
    logic        lsm_en;
    logic [2:0]  lsm_in;
    logic        lsm_detect;
    logic        lsm_end;
    logic        busy;
    logic [3:0]  reg_num;
    logic [7:0]  cur_off;
    logic [7:0]  wb_off;
    logic [4:0]  count;
    logic        l_bit;

    modport master (
        output ir, lsm_en, lsm_in,
        input  lsm_detect, lsm_end, busy, reg_num, cur_off, wb_off, count, l_bit
    );

    modport slave (
        input  ir, lsm_en, lsm_in,
        output lsm_detect, lsm_end, busy, reg_num, cur_off, wb_off, count, l_bit
    );

endinterface

// File: rtl/lsm_prio_enc.sv
// Lowest-set-bit priority encoder over a 16-bit register list.
module lsm_prio_enc (
    input  logic [15:0] in,
    output logic [3:0]  index,
    output logic        valid
);

    always_comb begin
        index = 4'd0;
        valid = |in;
        for (int i = 15; i >= 0; i--) begin
            if (in[i]) index = 4'(i);
        end
    end

endmodule

// File: rtl/lsm_sequencer.sv
// LDM/STM sequencer: latches a register list from IR and steps it one
// register per NEXT, supplying register number and byte offsets.
module lsm_sequencer
    import lsm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    lsm_sequencer_if.slave    bus
);

    lsm_state_t  state;
    logic [15:0] mask;
    logic [4:0]  idx;
    logic [4:0]  count_r;
    logic [3:0]  reg_num_r;
    logic [7:0]  cur_off_r;
    logic [7:0]  wb_off_r;
    logic [7:0]  start_off;
    logic        l_bit_r;

    logic [4:0]  pop;
    logic [4:0]  idx_inc;
    logic [7:0]  four_n;
    logic [7:0]  load_start;
    logic [15:0] mask_clr;
    logic [15:0] enc_in;
    logic [3:0]  enc_idx;
    logic        enc_valid;
    logic        unused_ir;

    assign unused_ir = ^{bus.ir[31:28], bus.ir[22:21], bus.ir[19:16]};

    always_comb begin
        pop = 5'd0;
        for (int i = 0; i < NREG; i++) pop = pop + 5'(bus.ir[i]);
    end

    assign four_n = 8'(WORD_BYTES) * {3'b000, pop};

    // Every mode keeps ascending registers at ascending addresses, so only the start differs
    always_comb begin
        load_start = 8'd0;
        case (bus.ir[24:23])
            MODE_IA: load_start = 8'd0;
            MODE_IB: load_start = 8'(WORD_BYTES);
            MODE_DA: load_start = 8'(WORD_BYTES) - four_n;
            MODE_DB: load_start = 8'd0 - four_n;
            default: load_start = 8'd0;
        endcase
    end

    // One encoder serves both LOAD (fresh list) and NEXT (list minus current bit)
    assign mask_clr = mask & (mask - 16'd1);
    assign enc_in   = (bus.lsm_in == LSM_LOAD) ? bus.ir[15:0] : mask_clr;
    assign idx_inc  = idx + 5'd1;

    lsm_prio_enc u_prio_enc (
        .in    (enc_in),
        .index (enc_idx),
        .valid (enc_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mask      <= 16'd0;
            idx       <= 5'd0;
            count_r   <= 5'd0;
            reg_num_r <= 4'd0;
            cur_off_r <= 8'd0;
            wb_off_r  <= 8'd0;
            start_off <= 8'd0;
            l_bit_r   <= 1'b0;
        end else if (bus.lsm_en) begin
            case (bus.lsm_in)
                LSM_LOAD: begin
                    mask      <= bus.ir[15:0];
                    count_r   <= pop;
                    l_bit_r   <= bus.ir[20];
                    idx       <= 5'd0;
                    reg_num_r <= enc_idx;
                    start_off <= load_start;
                    cur_off_r <= load_start;
                    wb_off_r  <= bus.ir[23] ? four_n : (8'd0 - four_n);
                    state     <= enc_valid ? ST_ACTIVE : ST_DONE;
                end
                LSM_NEXT: begin
                    if (state == ST_ACTIVE) begin
                        mask <= mask_clr;
                        if (enc_valid) begin
                            idx       <= idx_inc;
                            reg_num_r <= enc_idx;
                            cur_off_r <= start_off + 8'(WORD_BYTES) * {3'b000, idx_inc};
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                LSM_ABORT: begin
                    state <= ST_IDLE;
                    mask  <= 16'd0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.lsm_end = 1'b0;
        case (state)
            ST_ACTIVE: bus.lsm_end = (mask != 16'd0) && (mask_clr == 16'd0);
            ST_DONE:   bus.lsm_end = 1'b1;
            default:   bus.lsm_end = 1'b0;
        endcase
    end

    assign bus.lsm_detect = (bus.ir[27:25] == 3'b100);
    assign bus.busy       = (state == ST_ACTIVE);
    assign bus.reg_num    = reg_num_r;
    assign bus.cur_off    = cur_off_r;
    assign bus.wb_off     = wb_off_r;
    assign bus.count      = count_r;
    assign bus.l_bit      = l_bit_r;

endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed testbench for lsm_sequencer with hand-computed expected values.
module tb_lsm_sequencer;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    lsm_sequencer_if bus ();

    lsm_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a command at the falling edge, let it be sampled, then settle 1ns past the edge
    task automatic issue(input logic en, input logic [2:0] cmd, input logic [31:0] ir);
        @(negedge clk);
        bus.lsm_en = en;
        bus.lsm_in = cmd;
        bus.ir     = ir;
        @(posedge clk);
        #1;
        bus.lsm_en = 1'b0;
        bus.lsm_in = 3'b000;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.lsm_en = 1'b0;
        bus.lsm_in = 3'b000;
        bus.ir     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.lsm_end, bus.reg_num, bus.cur_off, bus.wb_off, bus.count, bus.l_bit} !== 31'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got busy=%b end=%b reg=%h cur=%h wb=%h cnt=%h l=%b expected all zero",
                     bus.busy, bus.lsm_end, bus.reg_num, bus.cur_off, bus.wb_off, bus.count, bus.l_bit);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_active();
        issue(1'b1, 3'b001, 32'hE8BD000F);
        checks++;
        if ({bus.busy, bus.count, bus.l_bit} !== {1'b1, 5'd4, 1'b1}) begin
            errors++;
            $display("[TB] FAIL mid_load: got busy=%b cnt=%0d l=%b expected busy=1 cnt=4 l=1",
                     bus.busy, bus.count, bus.l_bit);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.lsm_end, bus.reg_num, bus.cur_off, bus.wb_off, bus.count, bus.l_bit} !== 31'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got busy=%b end=%b reg=%h cur=%h wb=%h cnt=%h l=%b expected all zero",
                     bus.busy, bus.lsm_end, bus.reg_num, bus.cur_off, bus.wb_off, bus.count, bus.l_bit);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b1, 3'b010, 32'hE8BD000F);
        checks++;
        if ({bus.busy, bus.lsm_end, bus.reg_num, bus.cur_off} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL next_after_reset: got busy=%b end=%b reg=%h cur=%h expected all zero",
                     bus.busy, bus.lsm_end, bus.reg_num, bus.cur_off);
        end
    endtask

    task automatic test_ldmia();
        logic [3:0] exp_reg [3] = '{4'd0, 4'd2, 4'd7};
        logic [7:0] exp_off [3] = '{8'h00, 8'h04, 8'h08};
        logic       exp_end [3] = '{1'b0, 1'b0, 1'b1};
        issue(1'b1, 3'b001, 32'hE8900085);
        checks++;
        if ({bus.count, bus.wb_off, bus.l_bit, bus.busy} !== {5'd3, 8'h0C, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL ldmia_load: got cnt=%0d wb=%h l=%b busy=%b expected cnt=3 wb=0c l=1 busy=1",
                     bus.count, bus.wb_off, bus.l_bit, bus.busy);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.reg_num, bus.cur_off, bus.lsm_end} !== {exp_reg[i], exp_off[i], exp_end[i]}) begin
                errors++;
                $display("[TB] FAIL ldmia_step%0d: got reg=%0d cur=%h end=%b expected reg=%0d cur=%h end=%b",
                         i, bus.reg_num, bus.cur_off, bus.lsm_end, exp_reg[i], exp_off[i], exp_end[i]);
            end
            issue(1'b1, 3'b010, 32'hE8900085);
        end
        checks++;
        if ({bus.busy, bus.lsm_end, bus.reg_num, bus.cur_off} !== {1'b0, 1'b1, 4'd7, 8'h08}) begin
            errors++;
            $display("[TB] FAIL ldmia_done: got busy=%b end=%b reg=%0d cur=%h expected busy=0 end=1 reg=7 cur=08",
                     bus.busy, bus.lsm_end, bus.reg_num, bus.cur_off);
        end
    endtask

    task automatic test_stmdb();
        issue(1'b1, 3'b001, 32'hE92D4010);
        checks++;
        if ({bus.count, bus.wb_off, bus.l_bit, bus.reg_num, bus.cur_off, bus.lsm_end} !==
            {5'd2, 8'hF8, 1'b0, 4'd4, 8'hF8, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stmdb_first: got cnt=%0d wb=%h l=%b reg=%0d cur=%h end=%b expected cnt=2 wb=f8 l=0 reg=4 cur=f8 end=0",
                     bus.count, bus.wb_off, bus.l_bit, bus.reg_num, bus.cur_off, bus.lsm_end);
        end
        issue(1'b1, 3'b010, 32'hE92D4010);
        checks++;
        if ({bus.reg_num, bus.cur_off, bus.lsm_end, bus.busy} !== {4'd14, 8'hFC, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL stmdb_second: got reg=%0d cur=%h end=%b busy=%b expected reg=14 cur=fc end=1 busy=1",
                     bus.reg_num, bus.cur_off, bus.lsm_end, bus.busy);
        end
    endtask

    task automatic test_full_list();
        logic [7:0] exp_off;
        issue(1'b1, 3'b001, 32'hE99BFFFF);
        checks++;
        if ({bus.count, bus.wb_off} !== {5'd16, 8'h40}) begin
            errors++;
            $display("[TB] FAIL full_load: got cnt=%0d wb=%h expected cnt=16 wb=40", bus.count, bus.wb_off);
        end
        for (int i = 0; i < 16; i++) begin
            exp_off = 8'(4 + 4 * i);
            checks++;
            if ({bus.reg_num, bus.cur_off, bus.lsm_end} !== {4'(i), exp_off, (i == 15)}) begin
                errors++;
                $display("[TB] FAIL full_step%0d: got reg=%0d cur=%h end=%b expected reg=%0d cur=%h end=%b",
                         i, bus.reg_num, bus.cur_off, bus.lsm_end, i, exp_off, (i == 15));
            end
            issue(1'b1, 3'b010, 32'hE99BFFFF);
        end
        checks++;
        if ({bus.busy, bus.lsm_end} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL full_done: got busy=%b end=%b expected busy=0 end=1", bus.busy, bus.lsm_end);
        end
    endtask

    task automatic test_edge_cases();
        issue(1'b1, 3'b001, 32'hE8900000);
        checks++;
        if ({bus.busy, bus.lsm_end, bus.count, bus.reg_num, bus.wb_off, bus.cur_off} !==
            {1'b0, 1'b1, 5'd0, 4'd0, 8'h00, 8'h00}) begin
            errors++;
            $display("[TB] FAIL empty_list: got busy=%b end=%b cnt=%0d reg=%0d wb=%h cur=%h expected busy=0 end=1 zeros",
                     bus.busy, bus.lsm_end, bus.count, bus.reg_num, bus.wb_off, bus.cur_off);
        end
        issue(1'b1, 3'b001, 32'hE8900085);
        issue(1'b0, 3'b010, 32'hE8900085);
        checks++;
        if ({bus.busy, bus.reg_num, bus.cur_off} !== {1'b1, 4'd0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL en_low_next: got busy=%b reg=%0d cur=%h expected busy=1 reg=0 cur=00",
                     bus.busy, bus.reg_num, bus.cur_off);
        end
        issue(1'b1, 3'b110, 32'hE8900085);
        checks++;
        if ({bus.busy, bus.reg_num, bus.cur_off} !== {1'b1, 4'd0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL reserved_cmd: got busy=%b reg=%0d cur=%h expected busy=1 reg=0 cur=00",
                     bus.busy, bus.reg_num, bus.cur_off);
        end
        issue(1'b1, 3'b010, 32'hE8900085);
        issue(1'b1, 3'b011, 32'hE8900085);
        checks++;
        if ({bus.busy, bus.lsm_end, bus.reg_num} !== {1'b0, 1'b0, 4'd2}) begin
            errors++;
            $display("[TB] FAIL abort: got busy=%b end=%b reg=%0d expected busy=0 end=0 reg=2",
                     bus.busy, bus.lsm_end, bus.reg_num);
        end
        issue(1'b1, 3'b010, 32'hE8900085);
        checks++;
        if ({bus.busy, bus.lsm_end, bus.reg_num} !== {1'b0, 1'b0, 4'd2}) begin
            errors++;
            $display("[TB] FAIL next_in_idle: got busy=%b end=%b reg=%0d expected busy=0 end=0 reg=2",
                     bus.busy, bus.lsm_end, bus.reg_num);
        end
    endtask

    task automatic test_detect();
        logic [31:0] irs  [2] = '{32'hE5901000, 32'hE8BD8000};
        logic        dets [2] = '{1'b0, 1'b1};
        for (int s = 0; s < 3; s++) begin
            // s=0 IDLE, s=1 ACTIVE, s=2 DONE
            if (s == 1) issue(1'b1, 3'b001, 32'hE8900085);
            if (s == 2) issue(1'b1, 3'b001, 32'hE8900000);
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                bus.ir = irs[k];
                #1;
                checks++;
                if (bus.lsm_detect !== dets[k]) begin
                    errors++;
                    $display("[TB] FAIL detect_s%0d_ir%h: got %b expected %b", s, irs[k], bus.lsm_detect, dets[k]);
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_reset_mid_active();
        test_ldmia();
        test_stmdb();
        test_full_list();
        test_edge_cases();
        issue(1'b1, 3'b011, 32'h0);
        test_detect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
